ps2_digit_decoder: RTL and testbench
====================================

# ps2_digit_decoder

Receives PS/2 keyboard frames and turns digit key presses into a one-cycle `key_valid` pulse with a 4-bit binary digit on `last_change`. It sits directly upstream of the two-operand capture FSM, which consumes `key_valid`/`last_change` unchanged. Break codes, extended keys, non-digit keys and typematic repeats never produce a pulse.

## Interface
- `FILTER_LEN`, 8: number of consecutive equal synchronized `ps2_clk` samples required to change the filtered clock level (≥2).
- `TIMEOUT_CYC`, 200000: clk cycles without a filtered falling edge before a partial frame is abandoned (2 ms at 100 MHz).
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `ps2_clk`  in  1  raw PS/2 clock from the device, asynchronous to `clk`.
- `ps2_data`  in  1  raw PS/2 data, asynchronous to `clk`.
- `key_valid`  out  1  one-cycle pulse: a new digit press was decoded.
- `last_change`  out  4  digit 0–9 of the latest accepted press; holds until the next pulse.
- `frame_err`  out  1  one-cycle pulse on a parity, start, stop or timeout error.

## Operation
- Both PS/2 inputs pass through 2-flop synchronizers. `ps2_clk` goes through a FILTER_LEN shift filter. The filtered level goes to 0 only when all samples are 0 and to 1 only when all samples are 1. It resets to 1.
- Frame FSM: IDLE → DATA (8 bits, LSB first) → PARITY → STOP → IDLE. Each state advances on a filtered falling edge, and `ps2_data` is sampled at that edge.
- In IDLE, a sampled start bit of 1 is ignored and the FSM stays in IDLE.
- Parity is odd over the 8 data bits plus the parity bit. A wrong parity or a stop bit of 0 discards the byte and pulses `frame_err`.
- Timeout: in any state other than IDLE, a run of TIMEOUT_CYC cycles with no falling edge returns the FSM to IDLE, pulses `frame_err`, and clears the prefix flags.
- Byte decoder flags: `brk` is set by 0xF0 and `ext` by 0xE0. The next non-prefix byte consumes both flags and then clears them.
- Digit map, top row: 45→0, 16→1, 1E→2, 26→3, 25→4, 2E→5, 36→6, 3D→7, 3E→8, 46→9.
- Digit map, keypad: 70→0, 69→1, 72→2, 7A→3, 6B→4, 73→5, 74→6, 6C→7, 75→8, 7D→9.
- Any byte with `ext` set is ignored apart from clearing the flags. Unmapped codes are ignored.
- Repeat suppression: a register `held` (8-bit code plus a valid bit), reset to empty.
  - A make of a mapped code equal to `held` is suppressed.
  - Any other mapped make emits a pulse and replaces `held`.
  - A break of the `held` code empties it. A break of any other code leaves it unchanged.

## Timing
- Reset values: `key_valid`=0, `last_change`=0, `frame_err`=0, frame FSM=IDLE, `brk`/`ext`=0, `held` empty, filtered clock=1.
- Raw edge to filtered edge: 2 + FILTER_LEN clk cycles.
- The stop bit is sampled at cycle N. The internal `byte_valid` pulses at N+1. `key_valid` and the updated `last_change` appear together at N+2 and stay for exactly one cycle.
- `frame_err` asserts at N+1 for a stop or parity error. For a timeout it asserts the cycle the counter reaches TIMEOUT_CYC.
- `rst` mid-frame aborts the frame immediately. No pulse is emitted after `rst` is released until a complete new frame arrives.
- The downstream stage needs no handshake. The PS/2 minimum byte spacing is about 1 ms, so consecutive pulses are always ≥1000 cycles apart.

## Structure
- Shared package `ps2_pkg`:
  - prefix constants `PS2_EXT`=8'hE0 and `PS2_BRK`=8'hF0;
  - the digit scan-code constants;
  - the frame FSM state enum;
  - a function `scan_to_digit(code) → {hit, digit[3:0]}`.
- One sub-module, `ps2_rx`: synchronizers, filter, frame FSM and timeout. Its outputs are `byte_out[7:0]`, `byte_valid` and `frame_err`.
- The top level holds the prefix flags, the `held` register and the output registers.

## Test plan
Bench settings: FILTER_LEN=4, TIMEOUT_CYC=2000, PS/2 half-period 50 clk.
- Frame 0x16 with correct odd parity → one `key_valid` pulse at stop-sample+2, `last_change`=1, `frame_err`=0.
- Sequence 0x3E, 0x3E, 0x3E (typematic), then F0 3E → exactly one pulse (`last_change`=8). A following 0x3E → a second pulse.
- Sequence E0 70, then 0x1C, then F0 70 → no `key_valid` at all; `last_change` holds its previous value.
- Frame 0x45 with its parity bit flipped → `frame_err` pulse, no `key_valid`. A following valid 0x7D → `last_change`=9.
- Start bit, 4 data bits, then the clock stops high → `frame_err` exactly TIMEOUT_CYC cycles after the last falling edge. The next full frame 0x26 → `last_change`=3.
- `rst` asserted during bit 5 of 0x2E → outputs 0 immediately and no pulse for that frame. A full 0x2E after release → `last_change`=5.
- 1-cycle glitches on `ps2_clk` during 0x25 → no extra bits; `last_change`=4.

Source files
------------

// File: rtl/ps2_digit_decoder_pkg.sv
// ----------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 digit decoder:
//   - prefix byte constants (extended / break)
//   - top-row and keypad scan codes for digits 0..9
//   - frame receiver FSM state enum
//   - scan_to_digit(): maps a scan code to {hit, digit}
// ----------------------------------------------------------------------------
package ps2_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    // Element [d] holds the scan code of digit d (element 0 is the rightmost).
    localparam logic [9:0][7:0] SC_TOP = {8'h46, 8'h3E, 8'h3D, 8'h36, 8'h2E,
                                          8'h25, 8'h26, 8'h1E, 8'h16, 8'h45};
    localparam logic [9:0][7:0] SC_KP  = {8'h7D, 8'h75, 8'h6C, 8'h74, 8'h73,
                                          8'h6B, 8'h7A, 8'h72, 8'h69, 8'h70};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    typedef struct packed {
        logic       hit;
        logic [3:0] digit;
    } digit_t;

    function automatic digit_t scan_to_digit(input logic [7:0] code);
        digit_t res;
        res = '0;
        for (int d = 0; d < 10; d++) begin
            if (code == SC_TOP[d[3:0]] || code == SC_KP[d[3:0]]) begin
                res.hit   = 1'b1;
                res.digit = d[3:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ps2_digit_decoder_if.sv
// ----------------------------------------------------------------------------
// ps2_digit_decoder_if
// Bundles the PS/2 line inputs and the decoded-key outputs.
//   ps2_clk, ps2_data : raw PS/2 lines (driven by the device side)
//   key_valid         : one-cycle pulse per accepted digit press
//   last_change[3:0]  : latest accepted digit
//   frame_err         : one-cycle pulse on a frame error or timeout
// master = device/stimulus side, slave = decoder side.
// ----------------------------------------------------------------------------
interface ps2_digit_decoder_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic       key_valid;
    logic [3:0] last_change;
    logic       frame_err;

    modport master (
        output ps2_clk, ps2_data,
        input  key_valid, last_change, frame_err
    );

    modport slave (
        input  ps2_clk, ps2_data,
        output key_valid, last_change, frame_err
    );
endinterface

// File: rtl/ps2_digit_decoder_rx.sv
// ----------------------------------------------------------------------------
// ps2_rx
// PS/2 byte receiver: 2-flop synchronizers, ps2_clk glitch filter, frame FSM
// (start, 8 data bits LSB first, odd parity, stop) and inactivity timeout.
// Ports:
//   clk, rst      : system clock, asynchronous active-high reset
//   i_ps2_clk     : raw PS/2 clock
//   i_ps2_data    : raw PS/2 data
//   o_byte_out    : received byte, valid with o_byte_valid
//   o_byte_valid  : one-cycle pulse, one clk after the stop-bit sample
//   o_frame_err   : one-cycle pulse on parity/stop error or timeout
//   o_timeout     : one-cycle pulse when a partial frame is abandoned
// ----------------------------------------------------------------------------
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic [7:0] o_byte_out,
    output logic       o_byte_valid,
    output logic       o_frame_err,
    output logic       o_timeout
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [1:0]            r_clk_sync;
    logic [1:0]            r_data_sync;
    logic [FILTER_LEN-2:0] r_clk_hist;
    logic                  r_filt;
    logic [FILTER_LEN-1:0] w_win;
    logic                  w_fall;
    logic                  w_data;

    // The filter window is the newest synchronized sample plus FILTER_LEN-1
    // older ones, so the filtered level moves 2 + FILTER_LEN cycles after
    // the raw edge.
    assign w_win  = {r_clk_hist, r_clk_sync[1]};
    assign w_fall = r_filt && (w_win == '0);
    assign w_data = r_data_sync[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
            r_clk_hist  <= '1;
            r_filt      <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], i_ps2_clk};
            r_data_sync <= {r_data_sync[0], i_ps2_data};
            r_clk_hist  <= w_win[FILTER_LEN-2:0];
            if (w_win == '0)
                r_filt <= 1'b0;
            else if (&w_win)
                r_filt <= 1'b1;
        end
    end

    rx_state_t       r_state;
    rx_state_t       w_state_next;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_shift;
    logic            r_par_ok;
    logic            r_stop_pend;
    logic            r_stop_bit;
    logic [TW-1:0]   r_to_cnt;
    logic [7:0]      r_byte_out;
    logic            r_byte_valid;
    logic            r_frame_err;
    logic            r_timeout;
    logic            w_timeout;
    logic            w_start;
    logic            w_data_bit;
    logic            w_par_bit;
    logic            w_stop_bit;

    assign w_timeout = (r_state != ST_IDLE) && !w_fall &&
                       (r_to_cnt == TW'(TIMEOUT_CYC - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    // Next-state logic; a start bit sampled as 1 is treated as line noise.
    always_comb begin
        w_state_next = r_state;
        if (w_timeout) begin
            w_state_next = ST_IDLE;
        end else if (w_fall) begin
            case (r_state)
                ST_IDLE:   if (!w_data) w_state_next = ST_DATA;
                ST_DATA:   if (r_bit_cnt == 3'd7) w_state_next = ST_PARITY;
                ST_PARITY: w_state_next = ST_STOP;
                ST_STOP:   w_state_next = ST_IDLE;
                default:   w_state_next = ST_IDLE;
            endcase
        end
    end

    // Output decode: which bit the current filtered edge samples
    always_comb begin
        w_start    = w_fall && (r_state == ST_IDLE) && !w_data;
        w_data_bit = w_fall && (r_state == ST_DATA);
        w_par_bit  = w_fall && (r_state == ST_PARITY);
        w_stop_bit = w_fall && (r_state == ST_STOP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_par_ok     <= 1'b0;
            r_stop_pend  <= 1'b0;
            r_stop_bit   <= 1'b0;
            r_to_cnt     <= '0;
            r_byte_out   <= '0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            if (w_start)
                r_bit_cnt <= '0;
            else if (w_data_bit)
                r_bit_cnt <= r_bit_cnt + 3'd1;

            if (w_data_bit)
                r_shift <= {w_data, r_shift[7:1]};

            // Odd parity: data bits plus parity bit must XOR to 1.
            if (w_par_bit)
                r_par_ok <= ^{r_shift, w_data};

            r_stop_pend <= w_stop_bit;
            if (w_stop_bit)
                r_stop_bit <= w_data;

            if (r_state == ST_IDLE || w_fall || w_timeout)
                r_to_cnt <= '0;
            else
                r_to_cnt <= r_to_cnt + TW'(1);

            if (r_stop_pend)
                r_byte_out <= r_shift;
            r_byte_valid <= r_stop_pend && r_stop_bit && r_par_ok;
            r_frame_err  <= (r_stop_pend && !(r_stop_bit && r_par_ok)) || w_timeout;
            r_timeout    <= w_timeout;
        end
    end

    assign o_byte_out   = r_byte_out;
    assign o_byte_valid = r_byte_valid;
    assign o_frame_err  = r_frame_err;
    assign o_timeout    = r_timeout;

endmodule

// File: rtl/ps2_digit_decoder.sv
// ----------------------------------------------------------------------------
// ps2_digit_decoder
// Turns PS/2 digit key presses (top row or keypad) into a one-cycle key_valid
// pulse with the binary digit on last_change. Break codes, extended keys,
// unmapped keys and typematic repeats produce no pulse.
// Ports:
//   clk, rst : system clock, asynchronous active-high reset
//   bus      : ps2_digit_decoder_if.slave (ps2_clk/ps2_data in,
//              key_valid/last_change/frame_err out)
// ----------------------------------------------------------------------------
module ps2_digit_decoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic                 clk,
    input  logic                 rst,
    ps2_digit_decoder_if.slave   bus
);

    logic [7:0] w_byte;
    logic       w_byte_valid;
    logic       w_frame_err;
    logic       w_timeout;
    digit_t     w_map;
    logic       w_held_match;

    ps2_rx #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .clk          (clk),
        .rst          (rst),
        .i_ps2_clk    (bus.ps2_clk),
        .i_ps2_data   (bus.ps2_data),
        .o_byte_out   (w_byte),
        .o_byte_valid (w_byte_valid),
        .o_frame_err  (w_frame_err),
        .o_timeout    (w_timeout)
    );

    logic       r_brk;
    logic       r_ext;
    logic [7:0] r_held_code;
    logic       r_held_vld;
    logic       r_key_valid;
    logic [3:0] r_last_change;

    assign w_map        = scan_to_digit(w_byte);
    assign w_held_match = r_held_vld && (r_held_code == w_byte);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_brk         <= 1'b0;
            r_ext         <= 1'b0;
            r_held_code   <= '0;
            r_held_vld    <= 1'b0;
            r_key_valid   <= 1'b0;
            r_last_change <= '0;
        end else begin
            r_key_valid <= 1'b0;
            if (w_timeout) begin
                r_brk <= 1'b0;
                r_ext <= 1'b0;
            end else if (w_byte_valid) begin
                if (w_byte == PS2_EXT) begin
                    r_ext <= 1'b1;
                end else if (w_byte == PS2_BRK) begin
                    r_brk <= 1'b1;
                end else begin
                    // Any non-prefix byte consumes both flags.
                    r_brk <= 1'b0;
                    r_ext <= 1'b0;
                    if (!r_ext && w_map.hit) begin
                        if (r_brk) begin
                            // Releasing the held key re-arms it; other
                            // releases leave the repeat filter alone.
                            if (w_held_match)
                                r_held_vld <= 1'b0;
                        end else if (!w_held_match) begin
                            r_key_valid   <= 1'b1;
                            r_last_change <= w_map.digit;
                            r_held_code   <= w_byte;
                            r_held_vld    <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign bus.key_valid   = r_key_valid;
    assign bus.last_change = r_last_change;
    assign bus.frame_err   = w_frame_err;

endmodule

// File: tb/tb_ps2_digit_decoder.sv
// ----------------------------------------------------------------------------
// tb_ps2_digit_decoder
// Scoreboard bench: the stimulus pushes the expected output event (key digit
// or frame error, with its clk cycle) when it drives the deciding PS/2 edge;
// a monitor pops and compares whenever key_valid or frame_err is seen.
// ----------------------------------------------------------------------------
module tb_ps2_digit_decoder;

    localparam int FL   = 4;
    localparam int TO   = 2000;
    localparam int HALF = 50;
    localparam int GAP  = 300;

    typedef struct {
        bit         is_err;
        logic [3:0] digit;
        int         cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    ps2_digit_decoder_if bus_if ();

    ps2_digit_decoder #(
        .FILTER_LEN  (FL),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every output event must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && (bus_if.key_valid || bus_if.frame_err)) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: key_valid=%0b frame_err=%0b last_change=%0d cycle=%0d, required no output",
                         bus_if.key_valid, bus_if.frame_err, bus_if.last_change, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (bus_if.frame_err !== e.is_err || bus_if.key_valid !== !e.is_err ||
                    (!e.is_err && bus_if.last_change !== e.digit) || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL event: got key_valid=%0b frame_err=%0b digit=%0d cycle=%0d, required %s digit=%0d cycle=%0d",
                             bus_if.key_valid, bus_if.frame_err, bus_if.last_change, cyc,
                             e.is_err ? "frame_err" : "key_valid", e.digit, e.cyc);
                end else begin
                    $display("txn %s digit=%0d cycle=%0d ok", e.is_err ? "frame_err" : "key", bus_if.last_change, cyc);
                end
            end
        end
    end

    task automatic check_val(input string name, input logic [3:0] got, input logic [3:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, got, req);
        end else begin
            $display("txn check %s = %0d ok", name, got);
        end
    endtask

    // kind: 0 none, 1 key pulse, 2 stop/parity error, 3 timeout
    task automatic push_exp(input int kind, input logic [3:0] dig, input int fall_cyc);
        exp_t e;
        e.digit = dig;
        e.is_err = (kind != 1);
        case (kind)
            1: e.cyc = fall_cyc + FL + 4;
            2: e.cyc = fall_cyc + FL + 3;
            default: e.cyc = fall_cyc + FL + 2 + TO;
        endcase
        if (kind != 0) sb.push_back(e);
    endtask

    // One PS/2 bit: data set while clock is high, then a full low phase.
    // gl inserts a 1-cycle glitch in the middle of each phase.
    task automatic ps2_bit(input bit v, input bit gl, input int kind, input logic [3:0] dig);
        bus_if.ps2_data = v;
        for (int i = 0; i < HALF; i++) begin
            @(negedge clk);
            bus_if.ps2_clk = (gl && i == HALF / 2) ? 1'b0 : 1'b1;
        end
        bus_if.ps2_clk = 1'b0;
        push_exp(kind, dig, cyc);
        for (int i = 0; i < HALF; i++) begin
            @(negedge clk);
            bus_if.ps2_clk = (gl && i == HALF / 2) ? 1'b1 : 1'b0;
        end
        bus_if.ps2_clk = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit gl,
                             input int kind, input logic [3:0] dig);
        bit p;
        p = ~(^b) ^ bad_par;
        ps2_bit(1'b0, gl, 0, 4'd0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], gl, 0, 4'd0);
        ps2_bit(p, gl, 0, 4'd0);
        ps2_bit(1'b1, gl, kind, dig);
        bus_if.ps2_data = 1'b1;
        repeat (GAP) @(negedge clk);
    endtask

    initial begin
        logic [7:0] b;
        rst = 1'b1;
        bus_if.ps2_clk  = 1'b1;
        bus_if.ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        check_val("reset_key_valid", {3'd0, bus_if.key_valid}, 4'd0);
        check_val("reset_last_change", bus_if.last_change, 4'd0);
        check_val("reset_frame_err", {3'd0, bus_if.frame_err}, 4'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // Single press of '1'
        send_byte(8'h16, 0, 0, 1, 4'd1);

        // Typematic repeats of '8' suppressed until its release
        send_byte(8'h3E, 0, 0, 1, 4'd8);
        send_byte(8'h3E, 0, 0, 0, 4'd0);
        send_byte(8'h3E, 0, 0, 0, 4'd0);
        send_byte(8'hF0, 0, 0, 0, 4'd0);
        send_byte(8'h3E, 0, 0, 0, 4'd0);
        send_byte(8'h3E, 0, 0, 1, 4'd8);

        // Extended key, unmapped key, release of a non-held key: no output
        send_byte(8'hE0, 0, 0, 0, 4'd0);
        send_byte(8'h70, 0, 0, 0, 4'd0);
        send_byte(8'h1C, 0, 0, 0, 4'd0);
        send_byte(8'hF0, 0, 0, 0, 4'd0);
        send_byte(8'h70, 0, 0, 0, 4'd0);
        check_val("hold_last_change", bus_if.last_change, 4'd8);

        // Parity error, then keypad '9'
        send_byte(8'h45, 1, 0, 2, 4'd0);
        send_byte(8'h7D, 0, 0, 1, 4'd9);

        // Partial frame (start + 4 data bits) then clock idles high
        b = 8'h26;
        ps2_bit(1'b0, 0, 0, 4'd0);
        for (int i = 0; i < 3; i++) ps2_bit(b[i], 0, 0, 4'd0);
        ps2_bit(b[3], 0, 3, 4'd0);
        bus_if.ps2_data = 1'b1;
        repeat (TO + 200) @(negedge clk);
        send_byte(8'h26, 0, 0, 1, 4'd3);

        // Reset asserted during bit 5 of 0x2E
        b = 8'h2E;
        ps2_bit(1'b0, 0, 0, 4'd0);
        for (int i = 0; i < 5; i++) ps2_bit(b[i], 0, 0, 4'd0);
        bus_if.ps2_data = b[5];
        repeat (HALF) @(negedge clk);
        bus_if.ps2_clk = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("midrst_key_valid", {3'd0, bus_if.key_valid}, 4'd0);
        check_val("midrst_last_change", bus_if.last_change, 4'd0);
        check_val("midrst_frame_err", {3'd0, bus_if.frame_err}, 4'd0);
        @(negedge clk);
        bus_if.ps2_clk  = 1'b1;
        bus_if.ps2_data = 1'b1;
        repeat (100) @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        send_byte(8'h2E, 0, 0, 1, 4'd5);

        // Glitches on ps2_clk must not add bits
        send_byte(8'h25, 0, 1, 1, 4'd4);
        check_val("final_last_change", bus_if.last_change, 4'd4);

        repeat (50) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL missing_events: got %0d events still pending, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
